// File: rtl/sstv_pkg.sv
// Shared definitions for the SSTV decoder blocks: FSM state encoding,
// default video band limits and a constant-evaluable clog2 helper.
package sstv_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } sstv_state_t;

    // Default SSTV luminance band, in Hz.
    localparam int FREQ_BLACK       = 1500;
    localparam int FREQ_WHITE       = 2300;
    localparam int FREQ_GRAY_MIDDLE = 1900;

    // Ceiling log2; clog2(1) = 0. Usable in parameter/port width expressions.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sstv_level_quant.sv
// Combinational frequency -> grey level quantiser. Builds LEVELS-1 evenly
// spaced thresholds across the video band and reports how many of them the
// input strictly exceeds. Anything at or below black maps to 0, anything
// above the top threshold (including above-band input) clamps to LEVELS-1.
module sstv_level_quant #(
    parameter int AVG_W      = 12,
    parameter int COLOR_BITS = 2,
    parameter int FREQ_BLACK = 1500,
    parameter int FREQ_WHITE = 2300
) (
    input  logic [AVG_W-1:0]      avg,
    output logic [COLOR_BITS-1:0] level
);

    localparam int LEVELS = 1 << COLOR_BITS;
    localparam int STEP   = (FREQ_WHITE - FREQ_BLACK) / LEVELS;

    if (FREQ_WHITE <= FREQ_BLACK) begin : g_bad_band
        $error("sstv_level_quant: FREQ_WHITE must exceed FREQ_BLACK");
    end
    if (((FREQ_WHITE - FREQ_BLACK) % LEVELS) != 0) begin : g_bad_step
        $error("sstv_level_quant: band width must divide evenly into LEVELS");
    end
    if ((COLOR_BITS < 1) || (COLOR_BITS > 4)) begin : g_bad_depth
        $error("sstv_level_quant: COLOR_BITS must be 1..4");
    end
    if (AVG_W > 31) begin : g_bad_width
        $error("sstv_level_quant: AVG_W must fit a signed int compare");
    end

    // above[k] is set when avg > FREQ_BLACK + k*STEP; thresholds are
    // monotonic, so the set bits form a thermometer code.
    logic [LEVELS-1:1] above;

    for (genvar k = 1; k < LEVELS; k++) begin : g_thresh
        assign above[k] = (int'(avg) > (FREQ_BLACK + k * STEP));
    end

    // Thermometer-to-binary: count thresholds exceeded.
    always_comb begin
        level = '0;
        for (int k = 1; k < LEVELS; k++) begin
            level = level + COLOR_BITS'(above[k]);
        end
    end

endmodule

// File: rtl/sstv_pixel_avg.sv
// SSTV pixel averager: sums SAMPLES_PER_PIXEL valid frequency samples per
// pixel, divides by shifting, quantises to grey and emits one registered
// pixel per window, with index and end-of-line strobe.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for line_start; freq_valid ignored
//   ACCUM | collecting samples for pixel pcnt of the current scanline
//
// A line_start seen in ACCUM normally aborts the line: the partial pixel is
// dropped and the same-cycle sample (if any) becomes the first sample of
// pixel 0. The exception is a line_start that lands on the sample finishing
// the last pixel: that pixel is still emitted with line_done and the new
// line starts empty.
module sstv_pixel_avg #(
    parameter int FREQ_W            = 12,
    parameter int COLOR_BITS        = 2,
    parameter int FREQ_BLACK        = sstv_pkg::FREQ_BLACK,
    parameter int FREQ_WHITE        = sstv_pkg::FREQ_WHITE,
    parameter int SAMPLES_PER_PIXEL = 4,
    parameter int PIXELS_PER_LINE   = 8,
    localparam int PIX_W = (sstv_pkg::clog2(PIXELS_PER_LINE) > 0) ?
                           sstv_pkg::clog2(PIXELS_PER_LINE) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic [FREQ_W-1:0]     freq,
    input  logic                  freq_valid,
    output logic [COLOR_BITS-1:0] pixel,
    output logic                  pixel_valid,
    output logic [PIX_W-1:0]      pixel_index,
    output logic                  line_done,
    output logic                  busy
);

    import sstv_pkg::*;

    localparam int SHIFT = clog2(SAMPLES_PER_PIXEL);
    localparam int ACC_W = FREQ_W + SHIFT;
    localparam int CNT_W = (SHIFT > 0) ? SHIFT : 1;

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES_PER_PIXEL - 1);
    localparam logic [PIX_W-1:0] LAST_PIXEL  = PIX_W'(PIXELS_PER_LINE - 1);

    if ((SAMPLES_PER_PIXEL < 1) || (SAMPLES_PER_PIXEL > 64) ||
        ((SAMPLES_PER_PIXEL & (SAMPLES_PER_PIXEL - 1)) != 0)) begin : g_bad_spp
        $error("sstv_pixel_avg: SAMPLES_PER_PIXEL must be a power of two in 1..64");
    end
    if (PIXELS_PER_LINE < 1) begin : g_bad_ppl
        $error("sstv_pixel_avg: PIXELS_PER_LINE must be at least 1");
    end

    sstv_state_t state, state_nx;

    logic [ACC_W-1:0]      acc, acc_nx, acc_base, sum;
    logic [CNT_W-1:0]      scnt, scnt_nx, scnt_base;
    logic [PIX_W-1:0]      pcnt, pcnt_nx, pcnt_base;
    logic [FREQ_W-1:0]     avg;
    logic [COLOR_BITS-1:0] level;

    logic take;
    logic finishing_line;
    logic restart;
    logic complete;
    logic last_pixel;
    logic emit;
    logic emit_done;

    // The accumulator holds at most SAMPLES_PER_PIXEL-1 full-scale samples
    // before the completing one is added, so ACC_W bits cannot overflow.
    assign take           = (state == ACCUM) && freq_valid;
    assign finishing_line = take && (scnt == LAST_SAMPLE) && (pcnt == LAST_PIXEL);
    assign restart        = (state == ACCUM) && line_start && !finishing_line;

    // On a restart the current sample is folded into a freshly cleared line.
    assign acc_base  = restart ? '0 : acc;
    assign scnt_base = restart ? '0 : scnt;
    assign pcnt_base = restart ? '0 : pcnt;

    assign sum        = acc_base + ACC_W'(freq);
    assign avg        = FREQ_W'(sum >> SHIFT);
    assign complete   = take && (scnt_base == LAST_SAMPLE);
    assign last_pixel = (pcnt_base == LAST_PIXEL);

    sstv_level_quant #(
        .AVG_W      (FREQ_W),
        .COLOR_BITS (COLOR_BITS),
        .FREQ_BLACK (FREQ_BLACK),
        .FREQ_WHITE (FREQ_WHITE)
    ) u_quant (
        .avg   (avg),
        .level (level)
    );

    // Next-state, counter and accumulator update; emit strobes for the output stage.
    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        scnt_nx   = scnt;
        pcnt_nx   = pcnt;
        emit      = 1'b0;
        emit_done = 1'b0;
        case (state)
            IDLE: begin
                if (line_start) begin
                    state_nx = ACCUM;
                    acc_nx   = '0;
                    scnt_nx  = '0;
                    pcnt_nx  = '0;
                end
            end
            ACCUM: begin
                acc_nx  = acc_base;
                scnt_nx = scnt_base;
                pcnt_nx = pcnt_base;
                if (complete) begin
                    emit    = 1'b1;
                    acc_nx  = '0;
                    scnt_nx = '0;
                    if (last_pixel) begin
                        emit_done = 1'b1;
                        pcnt_nx   = '0;
                        state_nx  = line_start ? ACCUM : IDLE;
                    end else begin
                        pcnt_nx = pcnt_base + PIX_W'(1);
                    end
                end else if (take) begin
                    acc_nx  = sum;
                    scnt_nx = scnt_base + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, accumulator and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            scnt  <= '0;
            pcnt  <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            scnt  <= scnt_nx;
            pcnt  <= pcnt_nx;
        end
    end

    // Registered pixel output; pixel and index hold between emissions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel       <= '0;
            pixel_index <= '0;
            pixel_valid <= 1'b0;
            line_done   <= 1'b0;
        end else begin
            pixel_valid <= emit;
            line_done   <= emit_done;
            if (emit) begin
                pixel       <= level;
                pixel_index <= pcnt_base;
            end
        end
    end

    assign busy = (state == ACCUM);

endmodule

// File: tb/tb_sstv_pixel_avg.sv
// Directed bench for sstv_pixel_avg: default instance plus COLOR_BITS=1,
// COLOR_BITS=3 and SAMPLES_PER_PIXEL=1 variants sharing the same stimulus.
module tb_sstv_pixel_avg;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        line_start = 1'b0;
    logic        freq_valid = 1'b0;
    logic [11:0] freq       = '0;

    logic [1:0] pixel;    logic pixel_valid; logic [2:0] pixel_index; logic line_done; logic busy;
    logic [0:0] c1_pixel; logic c1_valid;    logic [2:0] c1_index;    logic c1_done;   logic c1_busy;
    logic [2:0] c3_pixel; logic c3_valid;    logic [2:0] c3_index;    logic c3_done;   logic c3_busy;
    logic [1:0] s1_pixel; logic s1_valid;    logic [2:0] s1_index;    logic s1_done;   logic s1_busy;

    sstv_pixel_avg u_def (
        .clk(clk), .reset(reset), .line_start(line_start), .freq(freq), .freq_valid(freq_valid),
        .pixel(pixel), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
        .line_done(line_done), .busy(busy)
    );

    sstv_pixel_avg #(.COLOR_BITS(1)) u_c1 (
        .clk(clk), .reset(reset), .line_start(line_start), .freq(freq), .freq_valid(freq_valid),
        .pixel(c1_pixel), .pixel_valid(c1_valid), .pixel_index(c1_index),
        .line_done(c1_done), .busy(c1_busy)
    );

    sstv_pixel_avg #(.COLOR_BITS(3)) u_c3 (
        .clk(clk), .reset(reset), .line_start(line_start), .freq(freq), .freq_valid(freq_valid),
        .pixel(c3_pixel), .pixel_valid(c3_valid), .pixel_index(c3_index),
        .line_done(c3_done), .busy(c3_busy)
    );

    sstv_pixel_avg #(.SAMPLES_PER_PIXEL(1)) u_s1 (
        .clk(clk), .reset(reset), .line_start(line_start), .freq(freq), .freq_valid(freq_valid),
        .pixel(s1_pixel), .pixel_valid(s1_valid), .pixel_index(s1_index),
        .line_done(s1_done), .busy(s1_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int pix;
        int idx;
        int ld;
        int cyc;
    } emit_t;

    emit_t q_def[$];
    emit_t q_c1[$];
    emit_t q_c3[$];
    emit_t q_s1[$];
    int    orphan = 0;

    // Record every emission with the cycle it became visible.
    always @(negedge clk) begin
        if (pixel_valid) q_def.push_back('{int'(pixel), int'(pixel_index), int'(line_done), cyc});
        if (c1_valid)    q_c1.push_back('{int'(c1_pixel), int'(c1_index), int'(c1_done), cyc});
        if (c3_valid)    q_c3.push_back('{int'(c3_pixel), int'(c3_index), int'(c3_done), cyc});
        if (s1_valid)    q_s1.push_back('{int'(s1_pixel), int'(s1_index), int'(s1_done), cyc});
        if ((line_done && !pixel_valid) || (c1_done && !c1_valid) ||
            (c3_done && !c3_valid) || (s1_done && !s1_valid)) orphan++;
    end

    int n_chk = 0;
    int n_err = 0;
    int drv_cyc = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ls, input logic v, input int f);
        @(negedge clk);
        line_start = ls;
        freq_valid = v;
        freq       = 12'(f);
        drv_cyc    = cyc;
    endtask

    task automatic clear_q();
        q_def.delete();
        q_c1.delete();
        q_c3.delete();
        q_s1.delete();
    endtask

    // Hand-computed levels for each constant sweep frequency.
    int sweep_f[11] = '{0, 1500, 1700, 1701, 1900, 1901, 2100, 2101, 2300, 2301, 4095};
    int exp_def[11] = '{0, 0, 0, 1, 1, 2, 2, 3, 3, 3, 3};
    int exp_c1[11]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int exp_c3[11]  = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 7, 7};

    // Mixed line: pixel 0 averages to 1900, pixel 1 to 1901, rest constant.
    int line_f[8]   = '{0, 0, 1950, 2150, 2300, 1600, 2000, 2500};
    int exp_line[8] = '{1, 2, 2, 3, 3, 0, 2, 3};

    function automatic int avg_samp(input int p, input int k);
        if (p == 0) return (k < 2) ? 1600 : 2200;
        if (p == 1) return (k < 2) ? 1600 : ((k == 2) ? 2200 : 2204);
        return line_f[p];
    endfunction

    int rs_idx[5] = '{0, 1, 2, 0, 1};
    int rs_pix[5] = '{1, 1, 1, 3, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int first;
        first = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pixel", int'(pixel), 0);
        chk("rst_valid", int'(pixel_valid), 0);
        chk("rst_index", int'(pixel_index), 0);
        chk("rst_done",  int'(line_done), 0);
        chk("rst_busy",  int'(busy), 0);
        reset = 1'b0;
        drive(1'b0, 1'b0, 0);

        // Constant-frequency sweep, one full line per value
        for (int s = 0; s < 11; s++) begin
            clear_q();
            drive(1'b1, 1'b0, 0);
            for (int k = 0; k < 32; k++) begin
                drive(1'b0, 1'b1, sweep_f[s]);
                if (k == 0) first = drv_cyc;
            end
            repeat (3) drive(1'b0, 1'b0, 0);
            chk($sformatf("sw%0d_count", s), q_def.size(), 8);
            for (int i = 0; i < q_def.size(); i++) begin
                chk($sformatf("sw%0d_pix%0d", s, i), q_def[i].pix, exp_def[s]);
                chk($sformatf("sw%0d_idx%0d", s, i), q_def[i].idx, i);
                chk($sformatf("sw%0d_ld%0d", s, i),  q_def[i].ld, (i == 7) ? 1 : 0);
                chk($sformatf("sw%0d_cyc%0d", s, i), q_def[i].cyc - first, 4 * (i + 1));
            end
            chk($sformatf("sw%0d_busy", s), int'(busy), 0);
            chk($sformatf("sw%0d_c1_count", s), q_c1.size(), 8);
            for (int i = 0; i < q_c1.size(); i++)
                chk($sformatf("sw%0d_c1_pix%0d", s, i), q_c1[i].pix, exp_c1[s]);
            chk($sformatf("sw%0d_c3_count", s), q_c3.size(), 8);
            for (int i = 0; i < q_c3.size(); i++)
                chk($sformatf("sw%0d_c3_pix%0d", s, i), q_c3[i].pix, exp_c3[s]);
            chk($sformatf("sw%0d_s1_count", s), q_s1.size(), 8);
            for (int i = 0; i < q_s1.size(); i++) begin
                chk($sformatf("sw%0d_s1_pix%0d", s, i), q_s1[i].pix, exp_def[s]);
                chk($sformatf("sw%0d_s1_idx%0d", s, i), q_s1[i].idx, i);
                chk($sformatf("sw%0d_s1_ld%0d", s, i),  q_s1[i].ld, (i == 7) ? 1 : 0);
                chk($sformatf("sw%0d_s1_cyc%0d", s, i), q_s1[i].cyc - first, i + 1);
            end
            chk($sformatf("sw%0d_s1_busy", s), int'(s1_busy), 0);
            chk($sformatf("sw%0d_c1_busy", s), int'(c1_busy), 0);
            chk($sformatf("sw%0d_c3_busy", s), int'(c3_busy), 0);
        end

        // Averaging over a continuous full line
        clear_q();
        drive(1'b1, 1'b0, 0);
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1'b0, 1'b1, avg_samp(p, k));
                if (p == 0 && k == 0) begin
                    first = drv_cyc;
                    chk("avg_busy_rise", int'(busy), 1);
                end
            end
        end
        repeat (3) drive(1'b0, 1'b0, 0);
        chk("avg_count", q_def.size(), 8);
        for (int i = 0; i < q_def.size(); i++) begin
            chk($sformatf("avg_pix%0d", i), q_def[i].pix, exp_line[i]);
            chk($sformatf("avg_idx%0d", i), q_def[i].idx, i);
            chk($sformatf("avg_ld%0d", i),  q_def[i].ld, (i == 7) ? 1 : 0);
            chk($sformatf("avg_cyc%0d", i), q_def[i].cyc - first, 4 * (i + 1));
        end
        chk("avg_busy_fall", int'(busy), 0);
        chk("avg_hold_pix", int'(pixel), 3);
        chk("avg_hold_idx", int'(pixel_index), 7);

        // Same line with freq_valid low every other cycle (junk freq when low)
        clear_q();
        drive(1'b1, 1'b0, 0);
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1'b0, 1'b1, avg_samp(p, k));
                if (p == 0 && k == 0) first = drv_cyc;
                drive(1'b0, 1'b0, 4095);
            end
        end
        repeat (3) drive(1'b0, 1'b0, 0);
        chk("gap_count", q_def.size(), 8);
        for (int i = 0; i < q_def.size(); i++) begin
            chk($sformatf("gap_pix%0d", i), q_def[i].pix, exp_line[i]);
            chk($sformatf("gap_idx%0d", i), q_def[i].idx, i);
            chk($sformatf("gap_ld%0d", i),  q_def[i].ld, (i == 7) ? 1 : 0);
            chk($sformatf("gap_cyc%0d", i), q_def[i].cyc - first, 8 * i + 7);
        end

        // line_start coincident with the completing sample of the last pixel
        clear_q();
        drive(1'b1, 1'b0, 0);
        for (int k = 0; k < 31; k++) drive(1'b0, 1'b1, 2100);
        drive(1'b1, 1'b1, 2100);
        first = drv_cyc;
        drive(1'b0, 1'b1, 1600);
        chk("co_busy", int'(busy), 1);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1600);
        repeat (3) drive(1'b0, 1'b0, 0);
        chk("co_count", q_def.size(), 9);
        if (q_def.size() == 9) begin
            chk("co_last_pix", q_def[7].pix, 2);
            chk("co_last_idx", q_def[7].idx, 7);
            chk("co_last_ld",  q_def[7].ld, 1);
            chk("co_last_cyc", q_def[7].cyc - first, 1);
            chk("co_new_pix",  q_def[8].pix, 0);
            chk("co_new_idx",  q_def[8].idx, 0);
            chk("co_new_ld",   q_def[8].ld, 0);
            chk("co_new_cyc",  q_def[8].cyc - first, 5);
        end
        chk("co_busy_after", int'(busy), 1);

        // Restart mid-pixel: partial pixel 3 dropped, same-cycle sample kept
        clear_q();
        drive(1'b1, 1'b0, 0);
        for (int k = 0; k < 14; k++) drive(1'b0, 1'b1, 1800);
        drive(1'b1, 1'b1, 2200);
        first = drv_cyc;
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 2200);
        for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, 1750);
        drive(1'b0, 1'b1, 2000);
        drive(1'b0, 1'b1, 2000);
        drive(1'b0, 1'b0, 0);
        chk("rs_count", q_def.size(), 5);
        for (int i = 0; i < q_def.size() && i < 5; i++) begin
            chk($sformatf("rs_idx%0d", i), q_def[i].idx, rs_idx[i]);
            chk($sformatf("rs_pix%0d", i), q_def[i].pix, rs_pix[i]);
            chk($sformatf("rs_ld%0d", i),  q_def[i].ld, 0);
        end
        if (q_def.size() >= 4) chk("rs_restart_cyc", q_def[3].cyc - first, 4);
        chk("rs_busy_pre", int'(busy), 1);
        chk("rs_pix_pre", int'(pixel), 1);
        chk("rs_idx_pre", int'(pixel_index), 1);

        // Asynchronous reset mid-line, sampled between clock edges
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pixel", int'(pixel), 0);
        chk("mid_rst_index", int'(pixel_index), 0);
        chk("mid_rst_valid", int'(pixel_valid), 0);
        chk("mid_rst_done",  int'(line_done), 0);
        chk("mid_rst_busy",  int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_q();
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 2000);
        repeat (2) drive(1'b0, 1'b0, 0);
        chk("idle_ignore_count", q_def.size(), 0);
        chk("idle_busy", int'(busy), 0);

        chk("orphan_line_done", orphan, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sstv_pixel_avg.md
# sstv_pixel_avg

Parametrised successor to the SSTV pixel colour decoder. It accumulates a fixed number of instantaneous frequency samples per pixel and averages them. It then quantises the average into 2^COLOR_BITS grey levels and emits one registered pixel per window, with a pixel index and an end-of-line strobe. It sits between the frequency estimator and the line buffer and consumes one scanline per `line_start`.

## Interface
- `FREQ_W`, 12: frequency sample width in Hz.
- `COLOR_BITS`, 2: output grey depth; LEVELS = 2^COLOR_BITS, range 1..4.
- `FREQ_BLACK`, 1500: lower bound of the video band, in Hz.
- `FREQ_WHITE`, 2300: upper bound of the video band, in Hz.
- `SAMPLES_PER_PIXEL`, 4: samples averaged per pixel; power of two, range 1..64.
- `PIXELS_PER_LINE`, 8: pixels per scanline, at least 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `line_start`  in  1  single-cycle strobe that (re)starts a scanline.
- `freq`  in  FREQ_W  instantaneous frequency sample.
- `freq_valid`  in  1  `freq` is valid this cycle.
- `pixel`  out  COLOR_BITS  quantised grey level; 0 = black.
- `pixel_valid`  out  1  one-cycle strobe: `pixel` and `pixel_index` are valid.
- `pixel_index`  out  clog2(PIXELS_PER_LINE)  position of the emitted pixel within the line.
- `line_done`  out  1  one-cycle strobe, coincident with `pixel_valid` of the last pixel.
- `busy`  out  1  high while in ACCUM.

## Operation
- States:
  - IDLE: ignores `freq_valid`. `line_start` moves to ACCUM and clears the accumulator, sample counter and pixel counter.
  - ACCUM: each `freq_valid` adds `freq` to the accumulator and increments the sample counter.
  - When the SAMPLES_PER_PIXEL-th sample is accepted:
    - compute avg = (acc + freq) >> log2(SAMPLES_PER_PIXEL);
    - quantise avg, register the result and emit it;
    - clear the accumulator and sample counter;
    - increment the pixel counter.
  - After the pixel with index PIXELS_PER_LINE-1: assert `line_done` and return to IDLE.
- Accumulator width is FREQ_W + log2(SAMPLES_PER_PIXEL). It never overflows and uses no saturation logic.
- Quantisation:
  - STEP = (FREQ_WHITE − FREQ_BLACK) / LEVELS, integer, elaborated as a constant.
  - Thresholds T_k = FREQ_BLACK + k·STEP, for k = 1..LEVELS−1.
  - `pixel` = the number of thresholds strictly exceeded by avg (avg > T_k).
  - avg ≤ FREQ_BLACK yields 0.
  - avg > FREQ_WHITE clamps to LEVELS−1. This is new behaviour: the previous decoder mapped above-band frequencies to black.
  - With the defaults this reproduces the legacy boundaries: ≤1700 → 0, 1701..1900 → 1, 1901..2100 → 2, >2100 → 3.
- `line_start` in ACCUM aborts the current line without emitting the partial pixel and restarts at pixel 0. The sample arriving in the same cycle as `line_start` is counted as the first sample of the new line.
- `line_start` coincident with the completing sample of the last pixel:
  - the pixel is still emitted with `line_done`;
  - the block stays in ACCUM for the new line with counters cleared.
- Gaps in `freq_valid` are permitted. The block only counts valid samples and has no timeout.
- Elaboration checks: SAMPLES_PER_PIXEL is a power of two; FREQ_WHITE > FREQ_BLACK; (FREQ_WHITE − FREQ_BLACK) divisible by LEVELS.

## Timing
- Reset values: state IDLE, `pixel` = 0, `pixel_valid` = 0, `pixel_index` = 0, `line_done` = 0, `busy` = 0, all counters and the accumulator 0.
- Latency: `pixel_valid` asserts on the rising edge after the cycle that accepted the completing sample (1 cycle).
- `pixel` and `pixel_index` hold their values until the next emission.
- `busy` rises on the edge after `line_start` and falls on the edge that asserts `line_done`.
- Back-to-back pixels are supported: with `freq_valid` continuously high, `pixel_valid` pulses every SAMPLES_PER_PIXEL cycles.
- Asserting `reset` mid-line immediately forces the reset values; no partial output is produced.

## Structure
- Shared package `sstv_pkg`: state enum {IDLE, ACCUM}, the default band constants FREQ_BLACK/FREQ_WHITE/FREQ_GRAY_MIDDLE, and a clog2 helper.
- Sub-module `sstv_level_quant`: combinational avg → level comparator bank over the generated thresholds. It is reused by the future colour-mode decoder.
- Top level contains the FSM, the counters and the accumulator.

## Test plan
All scenarios use default parameters.
- Sweep: constant `freq` F per pixel for F in {0, 1500, 1700, 1701, 1900, 1901, 2100, 2101, 2300, 2301, 4095}, one line per F → `pixel` = {0,0,0,1,1,2,2,3,3,3,3}; compare every value against the reference model.
- Averaging: samples 1600, 1600, 2200, 2200 (avg 1900) → `pixel` = 1. Samples 1600, 1600, 2200, 2204 (avg 1901) → `pixel` = 2.
- Full line: continuous valid samples → 8 `pixel_valid` pulses 4 cycles apart with `pixel_index` 0..7; `line_done` only with index 7; `busy` low afterwards.
- Gaps: `freq_valid` toggling every other cycle → pulses every 8 cycles; values unchanged from the continuous case.
- Restart: `line_start` after 2 samples of pixel 3 → no pulse for the partial pixel; next emission has `pixel_index` = 0. `reset` mid-line → all outputs 0 immediately.
- Parameter sweep: COLOR_BITS = 1 (thresholds 1900) and COLOR_BITS = 3 (STEP 100), plus SAMPLES_PER_PIXEL = 1 → levels match the model and latency is 1 cycle.
